mem_responder: RTL and testbench

Backing-memory responder for the direct-mapped read cache: the far end of the cache miss interface. On a cache miss it accepts the `MemRead` request and waits a fixed number of cycles to model memory latency. It then returns the addressed 32-bit word with a one-cycle `MemReadReady` pulse. A write port lets the bench or CPU store path preload and update contents.

---
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Backing-memory responder for the read cache miss path: fixed-latency word reads, write port always open.
// Optional MEM_RANGE_CHECK_EN: out-of-range reads return DEADBEEF with MemErr, out-of-range writes are dropped.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic [31:0] rdAddr,
    input  logic        MemWrite,
    input  logic [31:0] wrAddr,
    input  logic [31:0] wrData,
    output logic        MemReadReady,
    output logic [31:0] rdData,
    output logic        MemBusy,
`ifdef MEM_RANGE_CHECK_EN
    output logic        MemErr,
`endif
    output logic [1:0]  fsm_state
);
    localparam int IDXW = $clog2(DEPTH);

    // Handshake: MemRead is a level held by the cache until MemReadReady; it is
    // sampled only in IDLE, and MemReadReady is a one-cycle pulse with rdData valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    logic [31:0]     mem [DEPTH];
    state_t          state;
    logic [7:0]      cnt;
    logic [IDXW-1:0] addr_q;
    logic [IDXW-1:0] wr_idx;
    logic            wr_en;
    logic            unused_addr_bits;

    assign wr_idx    = wrAddr[IDXW-1:0];
    assign fsm_state = state;

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;
    assign wr_en            = MemWrite && (wrAddr[31:IDXW] == '0);
    assign unused_addr_bits = 1'b0;
`else
    assign wr_en            = MemWrite;
    assign unused_addr_bits = ^{rdAddr[31:IDXW], wrAddr[31:IDXW]};
`endif

    // Contents survive reset on purpose: the cache may re-request after a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            addr_q       <= '0;
            MemReadReady <= 1'b0;
            MemBusy      <= 1'b0;
            rdData       <= 32'h0;
`ifdef MEM_RANGE_CHECK_EN
            err_q        <= 1'b0;
            MemErr       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    MemReadReady <= 1'b0;
                    if (MemRead) begin
                        state   <= WAIT;
                        addr_q  <= rdAddr[IDXW-1:0];
                        cnt     <= 8'(LATENCY - 1);
                        MemBusy <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
                        err_q   <= (rdAddr[31:IDXW] != '0);
`endif
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state        <= READY;
                        MemReadReady <= 1'b1;
                        // A write landing on this same edge wins over the stored word.
                        if (wr_en && (wr_idx == addr_q)) begin
                            rdData <= wrData;
                        end else begin
                            rdData <= mem[addr_q];
                        end
`ifdef MEM_RANGE_CHECK_EN
                        if (err_q) begin
                            rdData <= 32'hDEADBEEF;
                            MemErr <= 1'b1;
                        end
`endif
                    end
                end
                READY: begin
                    state        <= IDLE;
                    MemReadReady <= 1'b0;
                    MemBusy      <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
                    MemErr       <= 1'b0;
`endif
                end
                default: begin
                    state        <= IDLE;
                    MemReadReady <= 1'b0;
                    MemBusy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized reads/writes against a
// transaction-level model (accept edge + latency, word array updated before the data-edge read).
module tb_mem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [31:0] rdAddr, wrAddr, wrData;
    logic        MemReadReady, MemBusy;
    logic [31:0] rdData;
    logic [1:0]  fsm_state;
`ifdef MEM_RANGE_CHECK_EN
    logic        MemErr;
`endif

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .rdAddr(rdAddr),
        .MemWrite(MemWrite), .wrAddr(wrAddr), .wrData(wrData),
        .MemReadReady(MemReadReady), .rdData(rdData), .MemBusy(MemBusy),
`ifdef MEM_RANGE_CHECK_EN
        .MemErr(MemErr),
`endif
        .fsm_state(fsm_state)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_q [$];
    bit          pending = 0;
    int          acc_m = 0;
    logic [31:0] req_a = 0;
    int          edge_no = 0;
    bit          exp_ready = 0, exp_busy = 0, exp_err = 0;
    logic [31:0] exp_data = 32'h0;

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return a >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pending = 0; exp_ready = 0; exp_busy = 0; exp_err = 0; exp_data = 32'h0;
            end else begin
                edge_no++;
                // Write first, so a read completing on this edge sees it.
                if (MemWrite && !out_of_range(wrAddr)) mem_m[wrAddr % DEPTH] = wrData;
                exp_ready = 0;
                exp_err   = 0;
                if (pending) begin
                    if (edge_no == acc_m + LATENCY) begin
                        exp_ready = 1;
                        exp_err   = out_of_range(req_a);
                        exp_data  = exp_err ? 32'hDEADBEEF : mem_m[req_a % DEPTH];
                        exp_q.push_back(exp_data);
                    end else if (edge_no == acc_m + LATENCY + 1) begin
                        pending = 0;
                    end
                end else if (MemRead) begin
                    pending = 1;
                    acc_m   = edge_no;
                    req_a   = rdAddr;
                end
                exp_busy = pending;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", {31'b0, MemReadReady}, {31'b0, exp_ready});
            check("busy", {31'b0, MemBusy}, {31'b0, exp_busy});
            check("rddata", rdData, exp_data);
`ifdef MEM_RANGE_CHECK_EN
            check("err", {31'b0, MemErr}, {31'b0, exp_err});
`endif
            if (MemReadReady) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_extra_pulse: got pulse with %h expected none", rdData);
                end else begin
                    check("sb_data", rdData, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        MemWrite = 1'b1; wrAddr = a; wrData = d;
        @(posedge clk); #1;
        MemWrite = 1'b0;
    endtask

    // mode 0: quiet, 1: random background writes, 2: write a/d on the data edge,
    // 3: write a/d one edge after the data edge.
    task automatic read_req(input logic [31:0] a, input int mode, input logic [31:0] d,
                            output logic [31:0] got, output int lat, output bit got_err);
        bit done = 0;
        int fwd_j;
        fwd_j = (mode == 2) ? LATENCY - 1 : (mode == 3) ? LATENCY : -1;
        got = 32'h0; lat = -1; got_err = 0;
        @(posedge clk); #1;
        MemRead = 1'b1; rdAddr = a;
        @(posedge clk); #1;
        rdAddr = a + 32'd4;
        for (int j = 0; j < 20 && !done; j++) begin
            if (mode == 1) begin
                MemWrite = 1'($urandom_range(0, 1));
                wrAddr = ($urandom_range(0, 3) == 0) ? a :
                         ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
                wrData = $urandom;
            end else begin
                MemWrite = (j == fwd_j); wrAddr = a; wrData = d;
            end
            @(negedge clk);
            if (MemReadReady) begin
                done = 1; lat = j; got = rdData;
`ifdef MEM_RANGE_CHECK_EN
                got_err = MemErr;
`endif
                MemRead = 1'b0;
            end
            @(posedge clk); #1;
        end
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL read_timeout: no MemReadReady for addr %h within 20 cycles", a);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] got;
    int          lat;
    bit          gerr;
    int          pulses;

    initial begin
        rst_n = 1'b0;
        MemRead = 1'($urandom); rdAddr = $urandom;
        MemWrite = 1'($urandom); wrAddr = $urandom; wrData = $urandom;
        #1;
        check("rst_ready", {31'b0, MemReadReady}, 32'h0);
        check("rst_busy", {31'b0, MemBusy}, 32'h0);
        check("rst_rddata", rdData, 32'h0);
`ifdef MEM_RANGE_CHECK_EN
        check("rst_err", {31'b0, MemErr}, 32'h0);
`endif
        MemRead = 1'b0; MemWrite = 1'b0;
        #20 rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);

        // basic read and latency
        write_word(5, 32'h12345678);
        read_req(5, 0, 0, got, lat, gerr);
        check("basic_data", got, 32'h12345678);
        check("basic_latency", lat, LATENCY);
        repeat (6) @(posedge clk);

        // address changes during WAIT are ignored
        write_word(9, 32'hA5A5A5A5);
        read_req(5, 0, 0, got, lat, gerr);
        check("addr_stable", got, 32'h12345678);

        // forwarding on the data edge, and a write one edge late
        write_word(7, 32'h0BAD0007);
        read_req(7, 2, 32'hCAFEF00D, got, lat, gerr);
        check("fwd_same_edge", got, 32'hCAFEF00D);
        write_word(7, 32'h77777777);
        read_req(7, 3, 32'hCAFEF00D, got, lat, gerr);
        check("fwd_late_old", got, 32'h77777777);
        read_req(7, 0, 0, got, lat, gerr);
        check("fwd_late_next", got, 32'hCAFEF00D);

        // reset in the middle of a request
        @(posedge clk); #1;
        MemRead = 1'b1; rdAddr = 5;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, MemBusy}, 32'h0);
        check("midrst_ready", {31'b0, MemReadReady}, 32'h0);
        #2 rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (MemReadReady) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        read_req(5, 0, 0, got, lat, gerr);
        check("midrst_reread", got, 32'h12345678);
        check("midrst_latency", lat, LATENCY);

        // upper address bits
        write_word(0, 32'h11);
        read_req(32'h100, 0, 0, got, lat, gerr);
`ifdef MEM_RANGE_CHECK_EN
        check("range_data", got, 32'hDEADBEEF);
        check("range_err", {31'b0, gerr}, 32'h1);
`else
        check("alias_data", got, 32'h11);
`endif
        write_word(32'h100, 32'h22);
        read_req(0, 0, 0, got, lat, gerr);
`ifdef MEM_RANGE_CHECK_EN
        check("range_wr_dropped", got, 32'h11);
`else
        check("alias_wr", got, 32'h22);
`endif

        // randomized traffic
        repeat (40) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
            read_req(a, $urandom_range(1, 3), $urandom, got, lat, gerr);
            check("rand_latency", lat, LATENCY);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        check("sb_leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
